multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Moore FSM sequencing the shared LEGv8 datapath (fetch, decode, execute, memory, writeback) one
//  instruction at a time. Drives the execute-stage controls (AluSrc, AluControl), PC/IR enables,
//  memory strobes and register writeback. Waits on memory readiness and counts retired instructions.
// PARAMETERS
//  CNT_W     32  width of retired-instruction counter
//  WAIT_MAX  16  max cycles to wait for mem_ready before timeout
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  instr_op       in   11     IR[31:21], valid from DECODE onward
//  zero_E         in   1      ALU zero flag from execute stage
//  mem_ready      in   1      memory completed request this cycle
//  IRWrite        out  1      latch instruction into IR and PC into PC_E
//  PCWrite        out  1      update PC
//  PCSrc          out  1      0: PC+4, 1: PCBranch_E
//  Reg2Loc        out  1      read reg2 from Rt (1) or Rm (0)
//  AluSrc         out  1      0: readData2_E, 1: signimm_E
//  AluControl     out  4      ALU operation
//  fetch_req      out  1      instruction memory request
//  memRead        out  1      data memory read request
//  memWrite       out  1      data memory write request
//  regWrite       out  1      register file write enable
//  memtoReg       out  1      writeback source: 0 ALU, 1 memory
//  instr_retired  out  1      one-cycle pulse per completed instruction
//  retired_count  out  CNT_W  retired instructions since reset, wraps
//  illegal_op     out  1      held high in HALT after undecodable op
//  mem_timeout    out  1      held high in HALT after wait overflow
// BEHAVIOUR
//  - Reset: state<=FETCH, retired_count<=0, wait_cnt<=0, flags<=0. All outputs 0 while reset is high.
//  - Outputs decode from state only. Exceptions: mem_ready gates IRWrite, PCWrite and the
//    retire pulse in memory states. zero_E gates PCSrc/PCWrite in EXEC_CBZ.
//  - FETCH: fetch_req=1. On mem_ready: IRWrite=1, PCWrite=1, PCSrc=0, go to DECODE. Else stay.
//  - DECODE (1 cycle): Reg2Loc=1 for STUR/CBZ, else 0.
//    ADD/SUB/AND/ORR go to EXEC_R. LDUR/STUR go to EXEC_MEM. CBZ goes to EXEC_CBZ.
//    B goes to EXEC_B. Any other op goes to HALT with illegal_op=1.
//  - Opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000,
//    LDUR 11111000010, STUR 11111000000, CBZ 10110100xxx, B 000101xxxxx.
//  - AluControl codes: AND 0000, ORR 0001, ADD 0010, SUB 0110, PASSB 0111. Default 0000.
//  - EXEC_R: AluSrc=0, AluControl per op, then WB_R.
//    WB_R: regWrite=1, memtoReg=0, retire, then FETCH.
//  - EXEC_MEM: AluSrc=1, AluControl=0010, then MEM_LD (LDUR) or MEM_ST (STUR).
//  - MEM_LD: memRead=1 until mem_ready, then WB_LD.
//    WB_LD: regWrite=1, memtoReg=1, retire, then FETCH.
//  - MEM_ST: memWrite=1 until mem_ready. On ready: retire, then FETCH.
//  - EXEC_CBZ: Reg2Loc=1, AluSrc=0, AluControl=0111, PCSrc=PCWrite=zero_E, retire, then FETCH.
//  - EXEC_B: PCSrc=1, PCWrite=1, retire, then FETCH.
//  - Branch targets use PC_E, which is latched at IRWrite. The PC+4 update in FETCH does not affect them.
//  - Latency per instruction, memory ready in 1 cycle: R=4, LDUR=5, STUR=4, CBZ/B=3.
//  - wait_cnt: clears on entry to FETCH/MEM_LD/MEM_ST and increments each cycle waiting there.
//    When it reaches WAIT_MAX without mem_ready: go to HALT, mem_timeout=1.
//    mem_ready in the same cycle as the limit counts as success.
//  - mem_ready outside FETCH/MEM_LD/MEM_ST is ignored.
//  - HALT: all enables and strobes 0. illegal_op/mem_timeout held. Exit only via reset.
//  - Retire pulse: instr_retired=1 for exactly one cycle and retired_count+=1, wrapping at 2^CNT_W.
//  - Reset mid-operation (incl. during a memory wait) drops the outstanding request.
//    Strobes are 0 in the same cycle. FETCH follows deassertion.
// STRUCTURE
//  - Package legv8_pkg: state_t enum (FETCH, DECODE, EXEC_R, EXEC_MEM, MEM_LD, MEM_ST, WB_R,
//    WB_LD, EXEC_CBZ, EXEC_B, HALT), opcode constants, AluControl constants, op-class enum.
//  - Sub-module op_decode: combinational instr_op to {op-class, AluControl}.
//  - Top holds the state register, wait counter, retire counter and output decode.
// TESTING
//  1. Reset, mem_ready=1, op ADD.
//     -> FETCH/DECODE/EXEC_R/WB_R. AluControl=0010 in EXEC_R, regWrite=1 in WB_R, retired_count=1 at cycle 4.
//  2. LDUR, mem_ready low 3 cycles in MEM_LD.
//     -> memRead high 4 cycles, then WB_LD with regWrite=memtoReg=1. Total latency 8.
//  3. CBZ with zero_E=1 -> PCWrite=PCSrc=1, AluControl=0111.
//     CBZ with zero_E=0 -> both 0, instr_retired still 1.
//  4. op 11111111111 -> HALT, illegal_op=1, all strobes 0 for 10+ cycles. Reset returns to FETCH, flag clears.
//  5. mem_ready held 0 in FETCH -> mem_timeout=1 after 16 cycles, HALT.
//     mem_ready at cycle 16 -> DECODE instead, no timeout.
//  6. Reset asserted mid MEM_ST wait -> memWrite=0 that cycle, FETCH next, retired_count=0.
//     Also: 2^CNT_W retires with CNT_W=4 -> count wraps to 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared types and constants for the LEGv8 multicycle controller.
package legv8_pkg;

    localparam int unsigned OP_W  = 11;
    localparam int unsigned ALU_W = 4;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_MEM,
        MEM_LD,
        MEM_ST,
        WB_R,
        WB_LD,
        EXEC_CBZ,
        EXEC_B,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        OPC_R,
        OPC_LDUR,
        OPC_STUR,
        OPC_CBZ,
        OPC_B,
        OPC_ILLEGAL
    } op_class_t;

    localparam logic [OP_W-1:0] OP_ADD  = 11'b10001011000;
    localparam logic [OP_W-1:0] OP_SUB  = 11'b11001011000;
    localparam logic [OP_W-1:0] OP_AND  = 11'b10001010000;
    localparam logic [OP_W-1:0] OP_ORR  = 11'b10101010000;
    localparam logic [OP_W-1:0] OP_LDUR = 11'b11111000010;
    localparam logic [OP_W-1:0] OP_STUR = 11'b11111000000;
    // CBZ and B carry immediate bits in the low part of the opcode field
    localparam logic [7:0]      OP_CBZ_PFX = 8'b10110100;
    localparam logic [5:0]      OP_B_PFX   = 6'b000101;

    localparam logic [ALU_W-1:0] ALU_AND   = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_ORR   = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD   = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB   = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_PASSB = 4'b0111;

    typedef struct packed {
        op_class_t        op_class;
        logic [ALU_W-1:0] alu_ctrl;
    } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the controller and the instruction/data memory.
interface multicycle_ctrl_if;
    logic fetch_req;
    logic memRead;
    logic memWrite;
    logic mem_ready;

    modport master (
        output fetch_req,
        output memRead,
        output memWrite,
        input  mem_ready
    );

    modport slave (
        input  fetch_req,
        input  memRead,
        input  memWrite,
        output mem_ready
    );
endinterface

// File: rtl/op_decode.sv
// Combinational opcode classifier: instr_op -> {op class, ALU control}.
module op_decode
    import legv8_pkg::*;
(
    input  logic [OP_W-1:0] instr_op,
    output dec_t            dec_c
);

    // Prefix-matched branches first, then exact-match R-type and memory ops
    always_comb begin
        dec_c.op_class = OPC_ILLEGAL;
        dec_c.alu_ctrl = ALU_AND;
        if (instr_op[10:5] == OP_B_PFX) begin
            dec_c.op_class = OPC_B;
        end else if (instr_op[10:3] == OP_CBZ_PFX) begin
            dec_c.op_class = OPC_CBZ;
            dec_c.alu_ctrl = ALU_PASSB;
        end else begin
            case (instr_op)
                OP_ADD: begin
                    dec_c.op_class = OPC_R;
                    dec_c.alu_ctrl = ALU_ADD;
                end
                OP_SUB: begin
                    dec_c.op_class = OPC_R;
                    dec_c.alu_ctrl = ALU_SUB;
                end
                OP_AND: begin
                    dec_c.op_class = OPC_R;
                    dec_c.alu_ctrl = ALU_AND;
                end
                OP_ORR: begin
                    dec_c.op_class = OPC_R;
                    dec_c.alu_ctrl = ALU_ORR;
                end
                OP_LDUR: begin
                    dec_c.op_class = OPC_LDUR;
                    dec_c.alu_ctrl = ALU_ADD;
                end
                OP_STUR: begin
                    dec_c.op_class = OPC_STUR;
                    dec_c.alu_ctrl = ALU_ADD;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the shared LEGv8 datapath, one instruction at a time.
module multicycle_ctrl
    import legv8_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    instr_op,
    input  logic               zero_E,
    multicycle_ctrl_if.master  mem,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               Reg2Loc,
    output logic               AluSrc,
    output logic [ALU_W-1:0]   AluControl,
    output logic               regWrite,
    output logic               memtoReg,
    output logic               instr_retired,
    output logic [CNT_W-1:0]   retired_count,
    output logic               illegal_op,
    output logic               mem_timeout
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                illegal_q, timeout_q;
    logic                retire, set_illegal, set_timeout;
    logic                fetch_req_c, mem_read_c, mem_write_c;
    logic                wait_at_max;
    dec_t                dec_c;

    op_decode u_op_decode (
        .instr_op (instr_op),
        .dec_c    (dec_c)
    );

    assign wait_at_max  = (wait_q == WAIT_W'(WAIT_MAX - 1));
    assign mem.fetch_req = fetch_req_c;
    assign mem.memRead   = mem_read_c;
    assign mem.memWrite  = mem_write_c;

    // State, wait counter, retire counter and sticky fault flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (retire)      cnt_q     <= cnt_q + CNT_W'(1);
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
        end
    end

    // Next-state and output decode; reset forces every output low in the same cycle
    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        retire        = 1'b0;
        set_illegal   = 1'b0;
        set_timeout   = 1'b0;
        IRWrite       = 1'b0;
        PCWrite       = 1'b0;
        PCSrc         = 1'b0;
        Reg2Loc       = 1'b0;
        AluSrc        = 1'b0;
        AluControl    = ALU_AND;
        fetch_req_c   = 1'b0;
        mem_read_c    = 1'b0;
        mem_write_c   = 1'b0;
        regWrite      = 1'b0;
        memtoReg      = 1'b0;
        illegal_op    = illegal_q;
        mem_timeout   = timeout_q;
        retired_count = cnt_q;

        case (state_q)
            FETCH: begin
                fetch_req_c = 1'b1;
                if (mem.mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end else if (wait_at_max) begin
                    set_timeout = 1'b1;
                    state_d     = HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            DECODE: begin
                Reg2Loc = (dec_c.op_class == OPC_STUR) || (dec_c.op_class == OPC_CBZ);
                case (dec_c.op_class)
                    OPC_R:    state_d = EXEC_R;
                    OPC_LDUR: state_d = EXEC_MEM;
                    OPC_STUR: state_d = EXEC_MEM;
                    OPC_CBZ:  state_d = EXEC_CBZ;
                    OPC_B:    state_d = EXEC_B;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = HALT;
                    end
                endcase
            end
            EXEC_R: begin
                AluControl = dec_c.alu_ctrl;
                state_d    = WB_R;
            end
            EXEC_MEM: begin
                AluSrc     = 1'b1;
                AluControl = ALU_ADD;
                state_d    = (dec_c.op_class == OPC_LDUR) ? MEM_LD : MEM_ST;
            end
            MEM_LD: begin
                mem_read_c = 1'b1;
                if (mem.mem_ready) begin
                    state_d = WB_LD;
                end else if (wait_at_max) begin
                    set_timeout = 1'b1;
                    state_d     = HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            MEM_ST: begin
                mem_write_c = 1'b1;
                if (mem.mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (wait_at_max) begin
                    set_timeout = 1'b1;
                    state_d     = HALT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WB_R: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            WB_LD: begin
                regWrite = 1'b1;
                memtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = FETCH;
            end
            EXEC_CBZ: begin
                Reg2Loc    = 1'b1;
                AluControl = ALU_PASSB;
                PCSrc      = zero_E;
                PCWrite    = zero_E;
                retire     = 1'b1;
                state_d    = FETCH;
            end
            EXEC_B: begin
                PCSrc   = 1'b1;
                PCWrite = 1'b1;
                retire  = 1'b1;
                state_d = FETCH;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase

        // Every wait window starts counting from zero
        if (state_d != state_q) wait_d = '0;

        if (reset) begin
            IRWrite       = 1'b0;
            PCWrite       = 1'b0;
            PCSrc         = 1'b0;
            Reg2Loc       = 1'b0;
            AluSrc        = 1'b0;
            AluControl    = ALU_AND;
            fetch_req_c   = 1'b0;
            mem_read_c    = 1'b0;
            mem_write_c   = 1'b0;
            regWrite      = 1'b0;
            memtoReg      = 1'b0;
            illegal_op    = 1'b0;
            mem_timeout   = 1'b0;
            retired_count = '0;
            retire        = 1'b0;
        end
        instr_retired = retire;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output checks plus a retire scoreboard.
module tb_multicycle_ctrl;

    localparam int unsigned CNT_W    = 4;
    localparam int unsigned WAIT_MAX = 16;

    typedef enum int {P_FETCH, P_DECODE, P_EXR, P_EXM, P_MLD, P_MST, P_WBR, P_WBLD,
                      P_CBZ, P_B, P_HALT_ILL, P_HALT_TO} phase_t;
    typedef enum int {K_R, K_LD, K_ST, K_CBZ, K_B, K_ILL} kind_t;

    typedef struct packed {
        logic       irw;
        logic       pcw;
        logic       pcsrc;
        logic       reg2loc;
        logic       alusrc;
        logic [3:0] alu;
        logic       fetch;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic       m2r;
        logic       ret;
        logic       ill;
        logic       to;
    } ovec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [10:0]      instr_op;
    logic             zero_E;
    logic             IRWrite, PCWrite, PCSrc, Reg2Loc, AluSrc;
    logic [3:0]       AluControl;
    logic             regWrite, memtoReg, instr_retired, illegal_op, mem_timeout;
    logic [CNT_W-1:0] retired_count;
    ovec_t            obs;

    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] model_cnt;
    logic [CNT_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if mif ();

    multicycle_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr_op      (instr_op),
        .zero_E        (zero_E),
        .mem           (mif),
        .IRWrite       (IRWrite),
        .PCWrite       (PCWrite),
        .PCSrc         (PCSrc),
        .Reg2Loc       (Reg2Loc),
        .AluSrc        (AluSrc),
        .AluControl    (AluControl),
        .regWrite      (regWrite),
        .memtoReg      (memtoReg),
        .instr_retired (instr_retired),
        .retired_count (retired_count),
        .illegal_op    (illegal_op),
        .mem_timeout   (mem_timeout)
    );

    assign obs = {IRWrite, PCWrite, PCSrc, Reg2Loc, AluSrc, AluControl, mif.fetch_req,
                  mif.memRead, mif.memWrite, regWrite, memtoReg, instr_retired,
                  illegal_op, mem_timeout};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic kind_t classify(input logic [10:0] op);
        kind_t k;
        casez (op)
            11'b10001011000, 11'b11001011000,
            11'b10001010000, 11'b10101010000: k = K_R;
            11'b11111000010:                  k = K_LD;
            11'b11111000000:                  k = K_ST;
            11'b10110100???:                  k = K_CBZ;
            11'b000101?????:                  k = K_B;
            default:                          k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic [3:0] alu_of(input logic [10:0] op);
        logic [3:0] a;
        case (op)
            11'b10001011000: a = 4'b0010;
            11'b11001011000: a = 4'b0110;
            11'b10001010000: a = 4'b0000;
            11'b10101010000: a = 4'b0001;
            default:         a = 4'b0000;
        endcase
        return a;
    endfunction

    function automatic ovec_t exp_vec(input phase_t ph, input logic regloc, input logic [3:0] alu,
                                      input logic z, input logic rdy);
        ovec_t v;
        v = '0;
        case (ph)
            P_FETCH:    begin v.fetch = 1'b1; v.irw = rdy; v.pcw = rdy; end
            P_DECODE:   v.reg2loc = regloc;
            P_EXR:      v.alu = alu;
            P_EXM:      begin v.alusrc = 1'b1; v.alu = 4'b0010; end
            P_MLD:      v.mrd = 1'b1;
            P_MST:      begin v.mwr = 1'b1; v.ret = rdy; end
            P_WBR:      begin v.rw = 1'b1; v.ret = 1'b1; end
            P_WBLD:     begin v.rw = 1'b1; v.m2r = 1'b1; v.ret = 1'b1; end
            P_CBZ:      begin v.reg2loc = 1'b1; v.alu = 4'b0111; v.pcsrc = z; v.pcw = z; v.ret = 1'b1; end
            P_B:        begin v.pcsrc = 1'b1; v.pcw = 1'b1; v.ret = 1'b1; end
            P_HALT_ILL: v.ill = 1'b1;
            P_HALT_TO:  v.to = 1'b1;
            default: ;
        endcase
        return v;
    endfunction

    // One clock cycle: drive mem_ready, compare all outputs mid-cycle, advance past the edge
    task automatic step_chk(input string tag, input phase_t ph, input logic regloc,
                            input logic [3:0] alu, input logic rdy);
        mif.mem_ready = rdy;
        @(negedge clk);
        check_eq(tag, 32'(obs), 32'(exp_vec(ph, regloc, alu, zero_E, rdy)));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        reset = 1'b1;
        mif.mem_ready = rdy;
        @(negedge clk);
        check_eq("reset_outs", 32'(obs), 32'd0);
        check_eq("reset_count", 32'(retired_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = '0;
        exp_q.delete();
    endtask

    task automatic do_instr(input logic [10:0] op, input int fwait, input int mwait, input logic z);
        kind_t      k;
        logic [3:0] a;
        logic       rl;
        k  = classify(op);
        a  = alu_of(op);
        rl = (k == K_ST) || (k == K_CBZ);
        instr_op = op;
        zero_E   = z;
        if (k != K_ILL) begin
            model_cnt = model_cnt + CNT_W'(1);
            exp_q.push_back(model_cnt);
        end
        for (int i = 0; i < fwait; i++) step_chk("fetch_wait", P_FETCH, 1'b0, 4'd0, 1'b0);
        step_chk("fetch", P_FETCH, 1'b0, 4'd0, 1'b1);
        step_chk("decode", P_DECODE, rl, 4'd0, 1'($urandom));
        case (k)
            K_R: begin
                step_chk("exec_r", P_EXR, 1'b0, a, 1'($urandom));
                step_chk("wb_r", P_WBR, 1'b0, 4'd0, 1'($urandom));
            end
            K_LD: begin
                step_chk("exec_mem_ld", P_EXM, 1'b0, 4'd0, 1'($urandom));
                for (int i = 0; i < mwait; i++) step_chk("mem_ld_wait", P_MLD, 1'b0, 4'd0, 1'b0);
                step_chk("mem_ld", P_MLD, 1'b0, 4'd0, 1'b1);
                step_chk("wb_ld", P_WBLD, 1'b0, 4'd0, 1'($urandom));
            end
            K_ST: begin
                step_chk("exec_mem_st", P_EXM, 1'b0, 4'd0, 1'($urandom));
                for (int i = 0; i < mwait; i++) step_chk("mem_st_wait", P_MST, 1'b0, 4'd0, 1'b0);
                step_chk("mem_st", P_MST, 1'b0, 4'd0, 1'b1);
            end
            K_CBZ: step_chk("exec_cbz", P_CBZ, 1'b0, 4'd0, 1'($urandom));
            K_B:   step_chk("exec_b", P_B, 1'b0, 4'd0, 1'($urandom));
            default: begin
                for (int i = 0; i < 12; i++) step_chk("halt_illegal", P_HALT_ILL, 1'b0, 4'd0, 1'($urandom));
            end
        endcase
    endtask

    // Scoreboard: each retire pulse pops the expected count and checks it after the edge
    always begin
        logic [CNT_W-1:0] e;
        @(negedge clk);
        if (reset === 1'b0 && instr_retired === 1'b1) begin
            check_eq("retire_queue_empty", 32'(exp_q.size() == 0), 32'd0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                @(posedge clk);
                #1;
                check_eq("retired_count", 32'(retired_count), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        instr_op      = '0;
        zero_E        = 1'b0;
        mif.mem_ready = 1'b0;
        model_cnt     = '0;
        do_reset(1'b1);

        // R-type, loads with memory stall, stores, branches
        do_instr(11'b10001011000, 0, 0, 1'b0);
        do_instr(11'b11111000010, 0, 3, 1'b0);
        do_instr(11'b11001011000, 0, 0, 1'b1);
        do_instr(11'b10001010000, 2, 0, 1'b0);
        do_instr(11'b10101010000, 0, 0, 1'b0);
        do_instr(11'b11111000000, 0, 1, 1'b0);
        do_instr(11'b10110100101, 0, 0, 1'b1);
        do_instr(11'b10110100010, 0, 0, 1'b0);
        do_instr(11'b00010111010, 0, 0, 1'b0);

        // Reset in the middle of a store wait drops the request and the count
        instr_op = 11'b11111000000;
        step_chk("st_fetch", P_FETCH, 1'b0, 4'd0, 1'b1);
        step_chk("st_decode", P_DECODE, 1'b1, 4'd0, 1'b0);
        step_chk("st_exec", P_EXM, 1'b0, 4'd0, 1'b0);
        step_chk("st_wait", P_MST, 1'b0, 4'd0, 1'b0);
        step_chk("st_wait", P_MST, 1'b0, 4'd0, 1'b0);
        do_reset(1'b0);
        mif.mem_ready = 1'b0;
        @(negedge clk);
        check_eq("post_reset_count", 32'(retired_count), 32'd0);
        check_eq("post_reset_fetch", 32'(obs), 32'(exp_vec(P_FETCH, 1'b0, 4'd0, 1'b0, 1'b0)));
        @(posedge clk);
        #1;

        // Undecodable opcode parks in HALT until reset
        do_instr(11'b11111111111, 0, 0, 1'b0);
        do_reset(1'b1);
        check_eq("illegal_cleared", 32'(illegal_op), 32'd0);

        // Fetch timeout after WAIT_MAX idle cycles
        instr_op = 11'b10001011000;
        for (int i = 0; i < int'(WAIT_MAX); i++) step_chk("fetch_to_wait", P_FETCH, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 10; i++) step_chk("halt_timeout", P_HALT_TO, 1'b0, 4'd0, 1'($urandom));
        do_reset(1'b0);

        // Ready on the last allowed wait cycle still succeeds
        do_instr(11'b10001011000, int'(WAIT_MAX) - 1, 0, 1'b0);

        // Counter wrap: fifteen more retires bring the 4-bit count back to zero
        for (int i = 0; i < 15; i++) do_instr({6'b000101, 5'($urandom)}, 0, 0, 1'b0);
        do_instr(11'b11111000010, 0, 0, 1'b0);
        step_chk("final_fetch", P_FETCH, 1'b0, 4'd0, 1'b0);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
